sdram_read_cache: RTL and testbench
===================================

Name: sdram_read_cache

Overview:
- Direct-mapped, write-through, no-write-allocate word cache between the CPU load/store port and sdram_interface, in the cpu_clk domain.
- Read hits return in one cycle without touching SDRAM.
- Read misses fill one word through sdram_interface.
- Writes always go through to SDRAM and update the cached word only on a hit.

Parameters:
- INDEX_BITS, 8, log2 of line count (256 one-word lines).
- ADDR_W, 32, CPU byte-address width.

Ports:
- cpu_clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- cpu_ren  in  1  read request, sampled when ready=1.
- cpu_wen  in  1  write request, sampled when ready=1.
- address  in  ADDR_W  byte address; bits [1:0] ignored.
- data_in  in  32  store data.
- byte_select_vector  in  4  active-high store byte enables.
- invalidate  in  1  clear all valid bits (fence.i), sampled when ready=1.
- data_out  out  32  load data.
- ready  out  1  high = idle and accepting; low = operation in flight.
- mem_ren  out  1  one-cycle read strobe to sdram_interface.
- mem_wen  out  1  one-cycle write strobe to sdram_interface.
- mem_address  out  ADDR_W  word-aligned address to sdram_interface.
- mem_data_out  out  32  write data to sdram_interface.
- mem_byte_select_vector  out  4  active-high byte enables, passed through (sdram_interface inverts).
- mem_data_in  in  32  read data from sdram_interface.
- mem_ready  in  1  sdram_interface ready.

Behaviour:
- Address split: index=address[INDEX_BITS+1:2], tag=address[ADDR_W-1:INDEX_BITS+2]; arrays are tag[], data[], valid[].
- Reset: state=IDLE; ready=1; mem_ren=mem_wen=0; data_out=0; mem_address=0; mem_data_out=0; mem_byte_select_vector=0; all valid[]=0.
  - Reset mid-operation aborts immediately. The SDRAM access is not cancelled; the cache ignores its completion.
- Request acceptance: cycle with ready=1. Priority is invalidate > cpu_ren > cpu_wen. Simultaneous ren+wen is treated as a read.
- IDLE, invalidate: clear all valid[] at the next edge; ready stays 1.
- IDLE, read hit (valid & tag match): data_out=data[index] at the next edge; ready stays 1; no mem strobe. Back-to-back hits sustain one per cycle.
- IDLE, read miss: latch address; ready=0 at the next edge; go to ISSUE.
- IDLE, write: latch address/data/byte enables; ready=0; go to ISSUE.
  - On a hit, merge data_in into data[index] per byte enable at the next edge (tag and valid unchanged).
  - On a miss, the array is untouched.
- ISSUE: if mem_ready=1, assert mem_ren or mem_wen for exactly this one cycle, then go to WAIT_BUSY. If mem_ready=0, hold in ISSUE with strobes low.
- WAIT_BUSY: wait for mem_ready=0, then go to WAIT_DONE. A guard counter gives a 4-cycle timeout: if mem_ready never drops, go to WAIT_DONE anyway.
- WAIT_DONE: on mem_ready=1:
  - Read: data_out=mem_data_in; data/tag/valid[index] filled.
  - Write: nothing captured.
  - Then ready=1 and state=IDLE at that same edge.
- Miss latency: ready low for at least 3 cycles plus the SDRAM service time. data_out is valid in the first cycle ready returns high.
- cpu_ren/cpu_wen/invalidate while ready=0 are ignored. The CPU must hold the request until it sees ready=1.
- Mem-side outputs are registered; no combinational path from cpu_* to mem_*.
- Arrays are written only in IDLE (write hit, invalidate) and WAIT_DONE (fill). No read-during-fill hazard exists.

Decomposition:
- sdram_cache_pkg: cache_state_t enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE); BUSY_TIMEOUT=4.
- Sub-module dm_cache_array: tag/data/valid storage.
  - Read: combinational on index.
  - Write: byte-enabled, one write port.
  - Invalidate: single-cycle clear of all valid bits.
- The FSM stays in sdram_read_cache.

Test Plan:
- Reset, then read 0x0000_0100 with memory model returning 0xDEADBEEF after 5 cycles → exactly one mem_ren pulse with mem_address=0x100; ready low throughout; data_out=0xDEADBEEF when ready returns. Repeat the read → data_out=0xDEADBEEF next cycle, ready never drops, no mem_ren.
- Write 0x0000_0100 data 0x11223344, byte_select_vector=4'b0011 after the fill → mem_wen pulse with mem_byte_select_vector=4'b0011. Subsequent read hit returns 0xDEAD3344.
- Read 0x0000_0500 (same index as 0x100 with INDEX_BITS=8, different tag) → miss fills. Then read 0x100 → miss again (eviction).
- Write to an uncached address 0x0000_0200, then read it → the write does not allocate; the read misses and issues mem_ren.
- Assert invalidate after 0x100 is cached, then read 0x100 → miss. Also assert cpu_ren+cpu_wen together → only mem_ren issued.
- Assert reset while in WAIT_DONE → next cycle ready=1, mem strobes 0; read of 0x100 misses.

Source files
------------

// File: rtl/sdram_cache_pkg.sv
// rtl/sdram_cache_pkg.sv - shared types and constants for the SDRAM read cache
package sdram_cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } cache_state_t;

  localparam int BUSY_TIMEOUT = 4;
  localparam int BUSY_CNT_W   = 2;

endpackage

// File: rtl/dm_cache_array.sv
// rtl/dm_cache_array.sv - direct-mapped tag/data/valid storage, async read, one byte-enabled write port
module dm_cache_array
  import sdram_cache_pkg::*;
#(
  parameter int INDEX_BITS = 8,
  parameter int TAG_W      = 22
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [31:0]           rd_data,
  output logic                  rd_valid,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [3:0]            wr_be,
  input  logic [31:0]           wr_data,
  input  logic                  fill_en,
  input  logic [TAG_W-1:0]      fill_tag,
  input  logic                  inv_all
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [31:0]      data_mem [LINES];
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] valid_d;

  assign rd_data  = data_mem[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_valid = valid_q[rd_index];

  always_comb begin
    valid_d = valid_q;
    if (inv_all) begin
      valid_d = '0;
    end else if (fill_en) begin
      valid_d[wr_index] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data carry no reset; valid_q alone decides whether a line is usable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          data_mem[wr_index][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
    if (fill_en) begin
      tag_mem[wr_index] <= fill_tag;
    end
  end

endmodule

// File: rtl/sdram_read_cache.sv
// rtl/sdram_read_cache.sv - direct-mapped write-through word cache in front of sdram_interface
module sdram_read_cache
  import sdram_cache_pkg::*;
#(
  parameter int INDEX_BITS = 8,
  parameter int ADDR_W     = 32
) (
  input  logic              cpu_clk,
  input  logic              reset,
  input  logic              cpu_ren,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  input  logic [3:0]        byte_select_vector,
  input  logic              invalidate,
  output logic [31:0]       data_out,
  output logic              ready,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_out,
  output logic [3:0]        mem_byte_select_vector,
  input  logic [31:0]       mem_data_in,
  input  logic              mem_ready
);

  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  cache_state_t state_q, state_d;
  logic                  ready_q, ready_d;
  logic [31:0]           data_out_q, data_out_d;
  logic                  mem_ren_q, mem_ren_d;
  logic                  mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0]     mem_address_q, mem_address_d;
  logic [31:0]           mem_data_out_q, mem_data_out_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic                  is_read_q, is_read_d;
  logic [BUSY_CNT_W-1:0] busy_cnt_q, busy_cnt_d;

  logic [INDEX_BITS-1:0] cpu_index;
  logic [TAG_W-1:0]      cpu_tag;
  logic [TAG_W-1:0]      arr_tag;
  logic [31:0]           arr_data;
  logic                  arr_valid;
  logic                  hit;

  logic                  wr_en;
  logic [INDEX_BITS-1:0] wr_index;
  logic [3:0]            wr_be;
  logic [31:0]           wr_data;
  logic                  fill_en;
  logic                  inv_all;

  assign cpu_index = address[INDEX_BITS+1:2];
  assign cpu_tag   = address[ADDR_W-1:INDEX_BITS+2];
  assign hit       = arr_valid && (arr_tag == cpu_tag);

  dm_cache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk      (cpu_clk),
    .reset    (reset),
    .rd_index (cpu_index),
    .rd_tag   (arr_tag),
    .rd_data  (arr_data),
    .rd_valid (arr_valid),
    .wr_en    (wr_en),
    .wr_index (wr_index),
    .wr_be    (wr_be),
    .wr_data  (wr_data),
    .fill_en  (fill_en),
    .fill_tag (mem_address_q[ADDR_W-1:INDEX_BITS+2]),
    .inv_all  (inv_all)
  );

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state_q        <= IDLE;
      ready_q        <= 1'b1;
      data_out_q     <= '0;
      mem_ren_q      <= 1'b0;
      mem_wen_q      <= 1'b0;
      mem_address_q  <= '0;
      mem_data_out_q <= '0;
      mem_be_q       <= '0;
      is_read_q      <= 1'b0;
      busy_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      ready_q        <= ready_d;
      data_out_q     <= data_out_d;
      mem_ren_q      <= mem_ren_d;
      mem_wen_q      <= mem_wen_d;
      mem_address_q  <= mem_address_d;
      mem_data_out_q <= mem_data_out_d;
      mem_be_q       <= mem_be_d;
      is_read_q      <= is_read_d;
      busy_cnt_q     <= busy_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (invalidate) begin
          state_d = IDLE;
        end else if (cpu_ren) begin
          if (!hit) state_d = ISSUE;
        end else if (cpu_wen) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready) state_d = WAIT_BUSY;
      end
      // Give up waiting for the busy acknowledge after BUSY_TIMEOUT cycles.
      WAIT_BUSY: begin
        if (!mem_ready || busy_cnt_q == BUSY_CNT_W'(BUSY_TIMEOUT - 1)) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_d        = ready_q;
    data_out_d     = data_out_q;
    mem_ren_d      = 1'b0;
    mem_wen_d      = 1'b0;
    mem_address_d  = mem_address_q;
    mem_data_out_d = mem_data_out_q;
    mem_be_d       = mem_be_q;
    is_read_d      = is_read_q;
    busy_cnt_d     = busy_cnt_q;
    wr_en          = 1'b0;
    wr_index       = cpu_index;
    wr_be          = byte_select_vector;
    wr_data        = data_in;
    fill_en        = 1'b0;
    inv_all        = 1'b0;
    case (state_q)
      IDLE: begin
        if (invalidate) begin
          inv_all = 1'b1;
        end else if (cpu_ren) begin
          if (hit) begin
            data_out_d = arr_data;
          end else begin
            ready_d       = 1'b0;
            is_read_d     = 1'b1;
            mem_address_d = address & ~ADDR_W'(3);
          end
        end else if (cpu_wen) begin
          ready_d        = 1'b0;
          is_read_d      = 1'b0;
          mem_address_d  = address & ~ADDR_W'(3);
          mem_data_out_d = data_in;
          mem_be_d       = byte_select_vector;
          wr_en          = hit;
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          mem_ren_d  = is_read_q;
          mem_wen_d  = !is_read_q;
          busy_cnt_d = '0;
        end
      end
      WAIT_BUSY: begin
        busy_cnt_d = busy_cnt_q + BUSY_CNT_W'(1);
      end
      WAIT_DONE: begin
        if (mem_ready) begin
          ready_d = 1'b1;
          if (is_read_q) begin
            data_out_d = mem_data_in;
            wr_en      = 1'b1;
            fill_en    = 1'b1;
            wr_index   = mem_address_q[INDEX_BITS+1:2];
            wr_be      = 4'hF;
            wr_data    = mem_data_in;
          end
        end
      end
      default: ;
    endcase
  end

  assign ready                  = ready_q;
  assign data_out               = data_out_q;
  assign mem_ren                = mem_ren_q;
  assign mem_wen                = mem_wen_q;
  assign mem_address            = mem_address_q;
  assign mem_data_out           = mem_data_out_q;
  assign mem_byte_select_vector = mem_be_q;

endmodule

// File: tb/tb_sdram_read_cache.sv
// tb/tb_sdram_read_cache.sv - table-driven bench with SDRAM model and load-data scoreboard
module tb_sdram_read_cache;

  logic        cpu_clk = 1'b0;
  logic        reset;
  logic        cpu_ren, cpu_wen, invalidate;
  logic [31:0] address, data_in;
  logic [3:0]  byte_select_vector;
  logic [31:0] data_out;
  logic        ready, mem_ren, mem_wen;
  logic [31:0] mem_address, mem_data_out;
  logic [3:0]  mem_byte_select_vector;
  logic [31:0] mem_data_in;
  logic        mem_ready;

  sdram_read_cache dut (
    .cpu_clk                (cpu_clk),
    .reset                  (reset),
    .cpu_ren                (cpu_ren),
    .cpu_wen                (cpu_wen),
    .address                (address),
    .data_in                (data_in),
    .byte_select_vector     (byte_select_vector),
    .invalidate             (invalidate),
    .data_out               (data_out),
    .ready                  (ready),
    .mem_ren                (mem_ren),
    .mem_wen                (mem_wen),
    .mem_address            (mem_address),
    .mem_data_out           (mem_data_out),
    .mem_byte_select_vector (mem_byte_select_vector),
    .mem_data_in            (mem_data_in),
    .mem_ready              (mem_ready)
  );

  always #5 cpu_clk = ~cpu_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // SDRAM model: drops mem_ready for mem_lat cycles after a strobe, or never in no_drop mode
  logic [31:0] mem_model [int];
  int          mem_lat = 5;
  bit          no_drop = 1'b0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(int'(a))) return mem_model[int'(a)];
    return 32'h5EED_0000 | {16'h0, a[15:0]};
  endfunction

  initial begin
    logic [31:0] a, wd, old;
    logic [3:0]  be;
    bit          is_wr;
    mem_ready   = 1'b1;
    mem_data_in = '0;
    forever begin
      @(posedge cpu_clk); #1;
      if (mem_ren || mem_wen) begin
        a     = mem_address;
        wd    = mem_data_out;
        be    = mem_byte_select_vector;
        is_wr = mem_wen;
        if (!no_drop) begin
          mem_ready = 1'b0;
          repeat (mem_lat) begin @(posedge cpu_clk); #1; end
        end
        if (is_wr) begin
          old = mem_rd(a);
          for (int b = 0; b < 4; b++) if (be[b]) old[8*b +: 8] = wd[8*b +: 8];
          mem_model[int'(a)] = old;
        end else begin
          mem_data_in = mem_rd(a);
        end
        mem_ready = 1'b1;
      end
    end
  end

  int          ren_cnt = 0, wen_cnt = 0, both_cnt = 0;
  logic [31:0] last_addr = '0, last_wdata = '0;
  logic [3:0]  last_be = '0;

  always @(negedge cpu_clk) begin
    if (mem_ren && mem_wen) both_cnt++;
    if (mem_ren) begin ren_cnt++; last_addr = mem_address; end
    if (mem_wen) begin
      wen_cnt++; last_addr = mem_address; last_be = mem_byte_select_vector; last_wdata = mem_data_out;
    end
  end

  logic [31:0] sb_q [$];

  task automatic run_op(input bit ren, input bit wen, input bit inv, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be,
                        output int low_cycles, output bit timed_out);
    cpu_ren = ren; cpu_wen = wen; invalidate = inv;
    address = addr; data_in = data; byte_select_vector = be;
    @(posedge cpu_clk); #1;
    cpu_ren = 1'b0; cpu_wen = 1'b0; invalidate = 1'b0;
    low_cycles = 0;
    timed_out  = 1'b0;
    while (!ready && !timed_out) begin
      low_cycles++;
      if (low_cycles > 200) timed_out = 1'b1;
      else begin @(posedge cpu_clk); #1; end
    end
  endtask

  typedef struct {
    bit          ren, wen, inv;
    logic [31:0] addr, data;
    logic [3:0]  be;
    bit          chk_data;
    logic [31:0] exp_data;
    int          exp_ren, exp_wen;
    bit          exp_low;
    logic [31:0] exp_maddr;
  } vec_t;

  function automatic vec_t mk(bit ren, bit wen, bit inv, logic [31:0] addr, logic [31:0] data,
                              logic [3:0] be, bit chk, logic [31:0] exp_d, int er, int ew,
                              bit low, logic [31:0] maddr);
    vec_t v;
    v.ren = ren; v.wen = wen; v.inv = inv; v.addr = addr; v.data = data; v.be = be;
    v.chk_data = chk; v.exp_data = exp_d; v.exp_ren = er; v.exp_wen = ew;
    v.exp_low = low; v.exp_maddr = maddr;
    return v;
  endfunction

  vec_t vecs [15];

  initial begin
    int          low, r0, w0;
    bit          tmo;
    logic [31:0] exp;
    string       tag;

    vecs[0]  = mk(1,0,0, 32'h100, 32'h0,        4'h0, 1, 32'hDEADBEEF, 1,0,1, 32'h100);
    vecs[1]  = mk(1,0,0, 32'h100, 32'h0,        4'h0, 1, 32'hDEADBEEF, 0,0,0, 32'h0);
    vecs[2]  = mk(0,1,0, 32'h100, 32'h11223344, 4'h3, 0, 32'h0,        0,1,1, 32'h100);
    vecs[3]  = mk(1,0,0, 32'h100, 32'h0,        4'h0, 1, 32'hDEAD3344, 0,0,0, 32'h0);
    vecs[4]  = mk(1,0,0, 32'h500, 32'h0,        4'h0, 1, 32'hCAFEF00D, 1,0,1, 32'h500);
    vecs[5]  = mk(1,0,0, 32'h100, 32'h0,        4'h0, 1, 32'hDEAD3344, 1,0,1, 32'h100);
    vecs[6]  = mk(0,1,0, 32'h200, 32'h55667788, 4'hF, 0, 32'h0,        0,1,1, 32'h200);
    vecs[7]  = mk(1,0,0, 32'h200, 32'h0,        4'h0, 1, 32'h55667788, 1,0,1, 32'h200);
    vecs[8]  = mk(1,0,0, 32'h203, 32'h0,        4'h0, 1, 32'h55667788, 0,0,0, 32'h0);
    vecs[9]  = mk(0,0,1, 32'h100, 32'h0,        4'h0, 0, 32'h0,        0,0,0, 32'h0);
    vecs[10] = mk(1,0,0, 32'h100, 32'h0,        4'h0, 1, 32'hDEAD3344, 1,0,1, 32'h100);
    vecs[11] = mk(1,1,0, 32'h500, 32'h99999999, 4'hF, 1, 32'hCAFEF00D, 1,0,1, 32'h500);
    vecs[12] = mk(1,0,0, 32'h102, 32'h0,        4'h0, 1, 32'hDEAD3344, 1,0,1, 32'h100);
    vecs[13] = mk(0,1,0, 32'h100, 32'hAABBCCDD, 4'hC, 0, 32'h0,        0,1,1, 32'h100);
    vecs[14] = mk(1,0,0, 32'h100, 32'h0,        4'h0, 1, 32'hAABB3344, 0,0,0, 32'h0);

    mem_model[32'h100] = 32'hDEADBEEF;
    mem_model[32'h500] = 32'hCAFEF00D;
    mem_model[32'h200] = 32'h0BADC0DE;

    reset = 1'b1; cpu_ren = 1'b0; cpu_wen = 1'b0; invalidate = 1'b0;
    address = '0; data_in = '0; byte_select_vector = '0;
    repeat (3) @(posedge cpu_clk);
    #1;
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_strobes", {30'b0, mem_ren, mem_wen}, 32'd0);
    check("rst_data_out", data_out, 32'h0);
    check("rst_mem_address", mem_address, 32'h0);
    check("rst_mem_data_out", mem_data_out, 32'h0);
    check("rst_mem_be", {28'b0, mem_byte_select_vector}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      r0 = ren_cnt; w0 = wen_cnt;
      if (vecs[i].chk_data) sb_q.push_back(vecs[i].exp_data);
      run_op(vecs[i].ren, vecs[i].wen, vecs[i].inv, vecs[i].addr, vecs[i].data, vecs[i].be, low, tmo);
      tag = $sformatf("v%0d", i);
      check({tag, "_timeout"}, {31'b0, tmo}, 32'd0);
      check({tag, "_ren_pulses"}, ren_cnt - r0, vecs[i].exp_ren);
      check({tag, "_wen_pulses"}, wen_cnt - w0, vecs[i].exp_wen);
      check({tag, "_ready_dropped"}, {31'b0, low > 0}, {31'b0, vecs[i].exp_low});
      if (vecs[i].exp_low) check({tag, "_min_latency"}, {31'b0, low >= 3}, 32'd1);
      if (vecs[i].exp_ren + vecs[i].exp_wen > 0) check({tag, "_mem_address"}, last_addr, vecs[i].exp_maddr);
      if (vecs[i].exp_wen > 0) begin
        check({tag, "_mem_be"}, {28'b0, last_be}, {28'b0, vecs[i].be});
        check({tag, "_mem_wdata"}, last_wdata, vecs[i].data);
      end
      if (vecs[i].chk_data) begin
        exp = sb_q.pop_front();
        check({tag, "_data_out"}, data_out, exp);
      end
    end

    // mem_ready never drops: 1 ISSUE + 4 WAIT_BUSY + 1 WAIT_DONE cycle with ready low
    no_drop = 1'b1;
    r0 = ren_cnt;
    sb_q.push_back(32'h5EED0904);
    run_op(1, 0, 0, 32'h904, 32'h0, 4'h0, low, tmo);
    check("tmo_timeout", {31'b0, tmo}, 32'd0);
    check("tmo_low_cycles", low, 32'd6);
    check("tmo_ren_pulses", ren_cnt - r0, 32'd1);
    exp = sb_q.pop_front();
    check("tmo_data_out", data_out, exp);
    no_drop = 1'b0;

    // Reset while in WAIT_DONE, then read again while SDRAM is still busy with the aborted fill
    cpu_ren = 1'b1; address = 32'h700;
    @(posedge cpu_clk); #1;
    cpu_ren = 1'b0;
    repeat (3) @(posedge cpu_clk);
    #1;
    check("abort_pre_ready", {31'b0, ready}, 32'd0);
    reset = 1'b1;
    @(posedge cpu_clk); #1;
    reset = 1'b0;
    check("abort_ready", {31'b0, ready}, 32'd1);
    check("abort_strobes", {30'b0, mem_ren, mem_wen}, 32'd0);
    check("abort_data_out", data_out, 32'h0);
    r0 = ren_cnt;
    sb_q.push_back(32'hAABB3344);
    run_op(1, 0, 0, 32'h100, 32'h0, 4'h0, low, tmo);
    check("abort_timeout", {31'b0, tmo}, 32'd0);
    check("abort_ren_pulses", ren_cnt - r0, 32'd1);
    exp = sb_q.pop_front();
    check("abort_data_out2", data_out, exp);
    check("never_both_strobes", both_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
